// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: round-robin owner selection for the shared 16:1 mux
// channel, with a hold limit, a one-cycle release gap and a registered data bit.
//
// Ports:
//   clk      - rising-edge clock
//   rst_n    - synchronous active-low reset
//   req      - per-requester request, held high while the channel is wanted
//   in       - data bits, bit i belongs to requester i
//   grant    - one-hot registered grant, zero when there is no owner
//   sel      - mux select, index of the current or last owner
//   valid    - high while a grant is active
//   data_out - in[sel] registered one cycle behind sel, zero when not valid
//   preempt  - one-cycle pulse when the owner is forced off by the hold limit
module mux16_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic [15:0] in,
    output logic [15:0] grant,
    output logic [3:0]  sel,
    output logic        valid,
    output logic        data_out,
    output logic        preempt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_HOLD - 1);

    state_t           state;
    logic [3:0]       ptr;
    logic [CNT_W-1:0] hold_cnt;

    logic             found;
    logic [3:0]       win;
    logic [3:0]       idx;

    // First requester at or after ptr in rotation order; the 4-bit add
    // supplies the 15->0 wrap.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        idx   = '0;
        for (int i = 0; i < 16; i++) begin
            idx = ptr + 4'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            grant    <= '0;
            sel      <= '0;
            valid    <= 1'b0;
            data_out <= 1'b0;
            preempt  <= 1'b0;
        end else begin
            data_out <= valid ? in[sel] : 1'b0;
            preempt  <= 1'b0;
            unique case (state)
                IDLE, GAP: begin
                    if (found) begin
                        state    <= GRANT;
                        grant    <= 16'(1) << win;
                        sel      <= win;
                        valid    <= 1'b1;
                        hold_cnt <= '0;
                    end else begin
                        state <= IDLE;
                        grant <= '0;
                        valid <= 1'b0;
                    end
                end
                GRANT: begin
                    // A voluntary release takes priority over the limit,
                    // so no preempt pulse when both coincide.
                    if (!req[sel]) begin
                        state <= GAP;
                        grant <= '0;
                        valid <= 1'b0;
                        ptr   <= sel + 4'd1;
                    end else if (hold_cnt == LIMIT) begin
                        state   <= GAP;
                        grant   <= '0;
                        valid   <= 1'b0;
                        ptr     <= sel + 4'd1;
                        preempt <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// tb_mux16_rr_arbiter: directed bench for mux16_rr_arbiter (MAX_HOLD = 8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mux16_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic [15:0] in;
    logic [15:0] grant;
    logic [3:0]  sel;
    logic        valid;
    logic        data_out;
    logic        preempt;

    int passed;
    int total;

    mux16_rr_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .in       (in),
        .grant    (grant),
        .sel      (sel),
        .valid    (valid),
        .data_out (data_out),
        .preempt  (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 16'hFFFF;
        in    = 16'hFFFF;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if ({grant, sel, valid, data_out, preempt} !== 23'd0)
                $display("FAIL reset cyc%0d: grant=%h sel=%0d valid=%b dout=%b pre=%b, want all 0",
                         c, grant, sel, valid, data_out, preempt);
            else passed++;
        end
        rst_n = 1'b1;
        req   = 16'h0000;
        in    = 16'h0000;
        tick();
        total++;
        if (valid !== 1'b0 || grant !== 16'h0)
            $display("FAIL idle: valid=%b grant=%h, want 0/0000", valid, grant);
        else passed++;
    endtask

    task automatic test_single();
        req = 16'h0020;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (grant !== 16'h0020 || sel !== 4'd5 || valid !== 1'b1)
                $display("FAIL single grant cyc%0d: grant=%h sel=%0d valid=%b, want 0020/5/1",
                         c, grant, sel, valid);
            else passed++;
        end
        req = 16'h0000;
        tick();
        total++;
        if (valid !== 1'b0 || grant !== 16'h0 || sel !== 4'd5 || preempt !== 1'b0)
            $display("FAIL single gap: valid=%b grant=%h sel=%0d pre=%b, want 0/0000/5/0",
                     valid, grant, sel, preempt);
        else passed++;
        tick();
        total++;
        if (valid !== 1'b0 || sel !== 4'd5)
            $display("FAIL single idle: valid=%b sel=%0d, want 0/5", valid, sel);
        else passed++;
        // Search now starts at 6, so 6 beats 5.
        req = 16'h0060;
        tick();
        total++;
        if (grant !== 16'h0040 || sel !== 4'd6)
            $display("FAIL single ptr: grant=%h sel=%0d, want 0040/6", grant, sel);
        else passed++;
        req = 16'h0000;
        tick();
        tick();
    endtask

    task automatic test_rotation();
        logic [3:0] owners [4];
        owners = '{4'd0, 4'd1, 4'd15, 4'd0};
        do_reset();
        req = 16'h8003;
        for (int o = 0; o < 4; o++) begin
            for (int c = 0; c < 8; c++) begin
                tick();
                total++;
                if (grant !== (16'h1 << owners[o]) || sel !== owners[o] ||
                    valid !== 1'b1 || preempt !== 1'b0)
                    $display("FAIL rot own%0d cyc%0d: grant=%h sel=%0d valid=%b pre=%b, want owner %0d",
                             o, c, grant, sel, valid, preempt, owners[o]);
                else passed++;
            end
            tick();
            total++;
            if (valid !== 1'b0 || grant !== 16'h0 || preempt !== 1'b1 || sel !== owners[o])
                $display("FAIL rot gap%0d: valid=%b grant=%h pre=%b sel=%0d, want 0/0000/1/%0d",
                         o, valid, grant, preempt, sel, owners[o]);
            else passed++;
        end
        req = 16'h0000;
        tick();
    endtask

    task automatic test_hold_limit();
        do_reset();
        req = 16'h0100;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 8; c++) begin
                tick();
                total++;
                if (valid !== 1'b1 || sel !== 4'd8 || preempt !== 1'b0 || grant !== 16'h0100)
                    $display("FAIL hold r%0d c%0d: valid=%b sel=%0d pre=%b grant=%h, want 1/8/0/0100",
                             r, c, valid, sel, preempt, grant);
                else passed++;
            end
            tick();
            total++;
            if (valid !== 1'b0 || sel !== 4'd8 || preempt !== 1'b1)
                $display("FAIL hold gap r%0d: valid=%b sel=%0d pre=%b, want 0/8/1",
                         r, valid, sel, preempt);
            else passed++;
        end
        req = 16'h0000;
        tick();
        tick();
    endtask

    task automatic test_data();
        logic [3:0]  owners [4];
        logic [15:0] nreq   [4];
        logic        bits   [4];
        owners = '{4'd3, 4'd4, 4'd12, 4'd1};
        nreq   = '{16'h0010, 16'h1000, 16'h0002, 16'h0000};
        bits   = '{1'b1, 1'b1, 1'b1, 1'b0};
        in  = 16'b1111_0101_0001_1000;
        do_reset();
        req = 16'h0008;
        for (int o = 0; o < 4; o++) begin
            tick();
            total++;
            if (valid !== 1'b1 || sel !== owners[o] || data_out !== 1'b0)
                $display("FAIL data grant%0d: valid=%b sel=%0d dout=%b, want 1/%0d/0",
                         o, valid, sel, data_out, owners[o]);
            else passed++;
            req = nreq[o];
            tick();
            total++;
            if (valid !== 1'b0 || data_out !== bits[o])
                $display("FAIL data gap%0d: valid=%b dout=%b, want 0/%b",
                         o, valid, data_out, bits[o]);
            else passed++;
        end
        tick();
        total++;
        if (valid !== 1'b0 || data_out !== 1'b0)
            $display("FAIL data idle: valid=%b dout=%b, want 0/0", valid, data_out);
        else passed++;
    endtask

    task automatic test_reset_mid();
        // ptr is 2 here; a reset must bring it back to 0.
        req = 16'h0080;
        for (int c = 0; c < 5; c++) tick();
        total++;
        if (sel !== 4'd7 || valid !== 1'b1)
            $display("FAIL mid setup: sel=%0d valid=%b, want 7/1", sel, valid);
        else passed++;
        rst_n = 1'b0;
        tick();
        total++;
        if (grant !== 16'h0 || valid !== 1'b0 || preempt !== 1'b0 || sel !== 4'd0)
            $display("FAIL mid reset: grant=%h valid=%b pre=%b sel=%0d, want 0000/0/0/0",
                     grant, valid, preempt, sel);
        else passed++;
        rst_n = 1'b1;
        req   = 16'h0081;
        tick();
        total++;
        if (grant !== 16'h0001 || sel !== 4'd0 || preempt !== 1'b0)
            $display("FAIL mid regrant: grant=%h sel=%0d pre=%b, want 0001/0/0",
                     grant, sel, preempt);
        else passed++;
        req = 16'h0000;
        tick();
        tick();
    endtask

    task automatic test_release_at_limit();
        req = 16'h0004;
        for (int c = 0; c < 8; c++) tick();
        total++;
        if (sel !== 4'd2 || valid !== 1'b1)
            $display("FAIL rel setup: sel=%0d valid=%b, want 2/1", sel, valid);
        else passed++;
        req = 16'h0000;
        tick();
        total++;
        if (valid !== 1'b0 || preempt !== 1'b0)
            $display("FAIL rel at limit: valid=%b pre=%b, want 0/0", valid, preempt);
        else passed++;
        tick();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        req    = 16'h0;
        in     = 16'h0;
        test_reset();
        test_single();
        test_rotation();
        test_hold_limit();
        test_data();
        test_reset_mid();
        test_release_at_limit();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

endmodule
